// File: rtl/logic_op_pkg.sv
// Shared types and the multi-operand bitwise fold for the logic_op_pipe datapath.
package logic_op_pkg;

    localparam int unsigned MAX_IN    = 8;
    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    typedef logic [MAX_IN-1:0][MAX_WIDTH-1:0] operand_arr_t;

    typedef struct packed {
        logic err;
        logic ones;
        logic zero;
    } flags_t;

    // Left-to-right fold over the first num_in operands; inverted ops invert the whole fold.
    function automatic logic [MAX_WIDTH-1:0] logic_fold(input logic [OP_W-1:0] op,
                                                        input operand_arr_t      opnd,
                                                        input int unsigned       num_in);
        logic [MAX_WIDTH-1:0] acc_and;
        logic [MAX_WIDTH-1:0] acc_or;
        logic [MAX_WIDTH-1:0] acc_xor;
        logic [MAX_WIDTH-1:0] res;
        acc_and = opnd[0];
        acc_or  = opnd[0];
        acc_xor = opnd[0];
        for (int unsigned k = 1; k < MAX_IN; k++) begin
            if (k < num_in) begin
                acc_and = acc_and & opnd[k];
                acc_or  = acc_or  | opnd[k];
                acc_xor = acc_xor ^ opnd[k];
            end
        end
        case (op)
            OP_AND:  res = acc_and;
            OP_OR:   res = acc_or;
            OP_XOR:  res = acc_xor;
            OP_NAND: res = ~acc_and;
            OP_NOR:  res = ~acc_or;
            OP_XNOR: res = ~acc_xor;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic register slice: loads whenever empty or draining on the same edge.
module logic_pipe_stage #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    output logic          up_ready_c,
    input  logic          down_ready,
    output logic          valid,
    output logic [PW-1:0] data
);

    assign up_ready_c = !valid || down_ready;

    // Empty slots hold zero so an idle upstream bus never leaks into the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (up_ready_c) begin
            valid <= up_valid;
            data  <= up_valid ? up_data : '0;
        end
    end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready bitwise logic unit folding NUM_IN operands with one op per beat.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic                    out_ones,
    output logic                    op_err,
    output logic [CNT_W-1:0]        txn_count
);

    localparam int unsigned DW  = NUM_IN * WIDTH;
    localparam int unsigned S1W = OP_W + DW;
    localparam int unsigned S2W = 3 + WIDTH;

    generate
        if (NUM_IN < 2 || NUM_IN > MAX_IN || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_param
            $error("logic_op_pipe: NUM_IN must be 2..8 and WIDTH 1..64");
        end
    endgenerate

    logic           rst_done;
    logic           s1_ready_c;
    logic           s1_valid;
    logic [S1W-1:0] s1_data;
    logic           s2_ready_c;
    logic [S2W-1:0] s2_data;
    logic [S2W-1:0] s2_next;

    operand_arr_t    opnd;
    logic [OP_W-1:0] s1_op;
    logic [WIDTH-1:0] fold_res;
    flags_t          fold_flags;
    flags_t          s2_flags;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    assign in_ready = rst_done && s1_ready_c;

    logic_pipe_stage #(.PW(S1W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_valid  (in_valid && rst_done),
        .up_data   ({in_op, in_data}),
        .up_ready_c(s1_ready_c),
        .down_ready(s2_ready_c),
        .valid     (s1_valid),
        .data      (s1_data)
    );

    // Fold and flag generation between the two slices.
    always_comb begin
        opnd = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            opnd[k][WIDTH-1:0] = s1_data[k*WIDTH +: WIDTH];
        end
        s1_op           = s1_data[DW +: OP_W];
        fold_res        = WIDTH'(logic_fold(s1_op, opnd, NUM_IN));
        fold_flags      = '0;
        fold_flags.err  = (s1_op > 3'(OP_XNOR));
        fold_flags.zero = (fold_res == '0);
        fold_flags.ones = (&fold_res);
        s2_next         = {fold_flags, fold_res};
    end

    logic_pipe_stage #(.PW(S2W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_valid  (s1_valid),
        .up_data   (s2_next),
        .up_ready_c(s2_ready_c),
        .down_ready(out_ready),
        .valid     (out_valid),
        .data      (s2_data)
    );

    assign s2_flags = flags_t'(s2_data[WIDTH +: 3]);
    assign out_data = s2_data[WIDTH-1:0];
    assign out_zero = s2_flags.zero;
    assign out_ones = s2_flags.ones;
    assign op_err   = s2_flags.err;

    // Completed output handshakes; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      txn_count <= '0;
        else if (out_valid && out_ready) txn_count <= txn_count + CNT_W'(1);
    end

endmodule
